// File: rtl/set_less_than_32b_pkg.sv
// Shared ALU package: datapath width, ALU opcode encoding and small helpers
// used by the set-less-than unit and its ripple adder.
package set_less_than_32b_pkg;

    // Operand width of the ALU datapath
    localparam int ALU_WIDTH = 32;

    // ALU opcode encoding; the SLT unit is selected by ALU_OP_SLT at the result mux
    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'h0,
        ALU_OP_SUB  = 4'h1,
        ALU_OP_AND  = 4'h2,
        ALU_OP_OR   = 4'h3,
        ALU_OP_XOR  = 4'h4,
        ALU_OP_SLL  = 4'h5,
        ALU_OP_SRL  = 4'h6,
        ALU_OP_SRA  = 4'h7,
        ALU_OP_SLT  = 4'h8,
        ALU_OP_SLTU = 4'h9
    } alu_op_e;

    // Signed overflow of a subtraction X - Y, from the operand and difference sign bits
    function automatic logic sub_overflow(input logic x_msb, input logic y_msb, input logic d_msb);
        return (x_msb != y_msb) && (d_msb != x_msb);
    endfunction

    // Signed less-than from the difference sign and the overflow flag
    function automatic logic slt_from_diff(input logic d_msb, input logic ovf);
        return d_msb ^ ovf;
    endfunction

endpackage

// File: rtl/set_less_than_32b_full_adder_1bit.sv
// One-bit full adder cell; chained WIDTH times to form the X + ~Y + 1 subtractor.
module full_adder_1bit
    import set_less_than_32b_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign s     = w_axb ^ cin;
    assign cout  = (a & b) | (cin & w_axb);

endmodule

// File: rtl/set_less_than_32b.sv
// Signed set-less-than unit: Z registers 1 when X < Y (two's complement).
// The compare is a ripple subtract X + ~Y + 1 with sign/overflow correction;
// the single-bit result is zero-extended downstream by the ALU.
module set_less_than_32b
    import set_less_than_32b_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [WIDTH-1:0]  X,
    input  logic signed [WIDTH-1:0]  Y,
    output logic                     Z
);

    logic        [WIDTH-1:0] w_y_inv;
    logic        [WIDTH-1:0] w_d;
    logic        [WIDTH:0]   w_c;
    logic                    w_unused_cout;
    logic                    w_v;
    logic                    w_lt;
    logic                    r_z;

    // Subtraction as addition of the inverted right operand with carry-in of one
    assign w_y_inv = ~Y;
    assign w_c[0]  = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ripple
            full_adder_1bit u_fa (
                .a    (X[gi]),
                .b    (w_y_inv[gi]),
                .cin  (w_c[gi]),
                .s    (w_d[gi]),
                .cout (w_c[gi+1])
            );
        end
    endgenerate

    // Carry-out only matters for an unsigned compare
    assign w_unused_cout = w_c[WIDTH];

    // Overflow flips the sign of the difference when operands have opposite signs
    assign w_v  = sub_overflow(X[WIDTH-1], Y[WIDTH-1], w_d[WIDTH-1]);
    assign w_lt = slt_from_diff(w_d[WIDTH-1], w_v);

    // Result register; reset wins over the incoming compare
    always_ff @(posedge clk) begin
        if (rst) begin
            r_z <= 1'b0;
        end else begin
            r_z <= w_lt;
        end
    end

    assign Z = r_z;

endmodule

// File: tb/tb_set_less_than_32b.sv
// Bench for set_less_than_32b: directed boundary cases, reset behaviour and
// random pairs against an arithmetic reference model.
module tb_set_less_than_32b;

    logic        clk;
    logic        rst;
    logic [31:0] X;
    logic [31:0] Y;
    logic        Z;

    int tests_run;
    int tests_failed;

    set_less_than_32b dut (
        .clk (clk),
        .rst (rst),
        .X   (X),
        .Y   (Y),
        .Z   (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: widen both operands to 64-bit signed integers and subtract
    function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return ((sa - sb) < 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: Z=%0b expected %0b", tag, obs, exp);
        end
    endtask

    // Apply operands, clock once, then check Z against the model
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b);
        X = a;
        Y = b;
        @(posedge clk);
        #1;
        check(tag, Z, rst ? 1'b0 : ref_lt(a, b));
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        tests_run    = 0;
        tests_failed = 0;

        // Reset held two cycles with operands that would otherwise give 1
        rst = 1'b1;
        X   = 32'h0000_0000;
        Y   = 32'h0000_0001;
        @(posedge clk); #1;
        check("reset_c0", Z, 1'b0);
        @(posedge clk); #1;
        check("reset_c1", Z, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset", Z, 1'b1);

        // Basic
        step("zero_zero",  32'h0000_0000, 32'h0000_0000);
        check("zero_zero_const", Z, 1'b0);
        step("zero_one",   32'h0000_0000, 32'h0000_0001);
        check("zero_one_const", Z, 1'b1);
        step("one_zero",   32'h0000_0001, 32'h0000_0000);
        check("one_zero_const", Z, 1'b0);

        // Signedness
        step("zero_m1",    32'h0000_0000, 32'hFFFF_FFFF);
        check("zero_m1_const", Z, 1'b0);
        step("m2_m1",      32'hFFFF_FFFE, 32'hFFFF_FFFF);
        check("m2_m1_const", Z, 1'b1);

        // Overflow
        step("max_m1",     32'h7FFF_FFFF, 32'hFFFF_FFFF);
        check("max_m1_const", Z, 1'b0);
        step("m1_70ff",    32'hFFFF_FFFF, 32'h70FF_FFFF);
        check("m1_70ff_const", Z, 1'b1);
        step("min_max",    32'h8000_0000, 32'h7FFF_FFFF);
        check("min_max_const", Z, 1'b1);
        step("max_min",    32'h7FFF_FFFF, 32'h8000_0000);
        check("max_min_const", Z, 1'b0);

        // Equality extremes
        step("min_min",    32'h8000_0000, 32'h8000_0000);
        check("min_min_const", Z, 1'b0);
        step("max_max",    32'h7FFF_FFFF, 32'h7FFF_FFFF);
        check("max_max_const", Z, 1'b0);

        // Random pairs with a mid-stream reset pulse
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ((i % 16) == 3) rb = ra;
            if ((i % 32) == 7) rb = ra ^ 32'h8000_0000;
            if (i == 5000) begin
                rst = 1'b1;
                step("rand_rst0", ra, rb);
                check("rand_rst0_zero", Z, 1'b0);
                step("rand_rst1", rb, ra);
                check("rand_rst1_zero", Z, 1'b0);
                rst = 1'b0;
            end
            step("rand", ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Overall time bound so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: sim time exceeded bound");
        $fatal(1, "timeout");
    end

endmodule
